packet_mux_arbiter: RTL
=======================

Name: packet_mux_arbiter

Overview:
- Round-robin scheduler that shares one WIDTH-bit output channel between 4 requesters, each using valid/ready handshakes.
- Computes the 2-bit select for the 4:1 data mux and registers the muxed beat into a one-entry output stage.
- Arbitrates only at packet boundaries: once a requester wins, it keeps the channel until it sends a beat with last=1.
- Sits between four producer streams and one downstream consumer.

Parameters:
- WIDTH, 4, data width of every requester and of the output.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- up_valid  input  4  bit i = requester i has a beat.
- up_last  input  4  bit i = requester i's beat ends its packet.
- up_data0..up_data3  input  WIDTH each  requester payloads.
- up_ready  output  4  bit i = requester i's beat is accepted this cycle (combinational).
- down_valid  output  1  output register holds a beat.
- down_ready  input  1  consumer accepts the beat.
- down_data  output  WIDTH  registered payload.
- down_last  output  1  registered last flag.
- down_src  output  2  index of the requester that produced the held beat.
- sel  output  2  combinational mux select, equal to the winner of the current cycle.

Behaviour:
- Reset (synchronous; rst sampled at an edge): all of the following take effect the next cycle.
  - Outputs: down_valid=0, down_data=0, down_last=0, down_src=0.
  - Internal: ptr=0, locked=0, gnt=0.
  - up_ready=0 while rst=1.
  - An in-flight packet is abandoned; no beat is emitted.
- load_en = up_valid[win] && (!down_valid || down_ready), where win is the winning requester index.
  - Full throughput: a new beat is loaded in the same cycle the held beat drains.
- States (encoded in the locked flag): ARB and LOCKED.
- ARB (locked=0):
  - win = first i with up_valid[i]=1, searching ptr, ptr+1, ... modulo 4.
  - If no requester is valid: sel holds the value of ptr, and nothing is loaded.
- LOCKED (locked=1):
  - win = gnt.
  - Other requesters' valid bits are ignored.
  - If up_valid[gnt]=0, there is no load and the state stays LOCKED. This is a bubble, not a release.
- On load_en:
  - up_ready[win]=1; all other up_ready bits are 0.
  - Next cycle: down_data = up_data[win], down_last = up_last[win], down_src = win, down_valid = 1.
- State updates on load_en:
  - Loaded beat has last=0: locked=1, gnt=win.
  - Loaded beat has last=1: locked=0, ptr = win+1 (2-bit wrap, so 3 -> 0).
  - A single-beat packet therefore never enters LOCKED.
- Output drain:
  - down_ready=1 with down_valid=1 and no load_en: down_valid=0 next cycle.
  - Drain and load in the same cycle: down_valid stays 1 with the new beat.
- down_valid=1 with down_ready=0: up_ready=0, and all down_* outputs hold stable.
- Latency: 1 cycle from accepted upstream beat to down_valid.
- The arbiter never drops or duplicates a beat.
- Output beats are never interleaved between packets.
- sel is combinational from ptr/locked/gnt/up_valid and is valid every cycle.

Decomposition:
- Package packet_mux_arbiter_pkg:
  - localparam N_REQ = 4.
  - typedef logic [1:0] req_idx_t, used by ptr, gnt, win, sel and down_src.
- Sub-module rr_pick4 (purely combinational):
  - Inputs: 4-bit request vector, req_idx_t ptr.
  - Outputs: found flag, req_idx_t index of the first set bit at or after ptr.
- The data mux is a case on win inside the top-level module.

Test Plan:
- Reset mid-packet:
  - Stimulus: req1 sends a 2-beat packet; assert rst after its first beat is accepted.
  - Required response: down_valid=0 and ptr=0 the cycle after rst. The next request from req2 is granted (it is the first valid bit searched from ptr=0). req1's second beat is not treated as a continuation.
- Round-robin fairness:
  - Stimulus: up_valid=4'b1111, all beats last=1, down_ready=1.
  - Required response: down_src sequence 0,1,2,3,0; one beat per cycle, with up_data values matching.
- Packet lock:
  - Stimulus: req2 sends a 3-beat packet (0xA, 0xB, 0xC(last)); req0 is valid throughout.
  - Required response: down_data A,B,C all with down_src=2, then req0. up_ready[0]=0 until C is loaded.
- Backpressure:
  - Stimulus: down_ready=0 for 3 cycles while holding 0x5.
  - Required response: down_data stays 0x5, up_ready=4'b0000. When down_ready rises, the next beat is loaded in the same cycle.
- Lock bubble:
  - Stimulus: req3 drops up_valid mid-packet for 2 cycles while req1 is valid.
  - Required response: no beat from req1 is accepted; req3 resumes and finishes the packet; then req1 wins (ptr wrapped to 0).

Source files
------------

// File: rtl/packet_mux_arbiter_pkg.sv
// rtl/packet_mux_arbiter_pkg.sv - shared types for the 4-requester packet mux arbiter
package packet_mux_arbiter_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] req_idx_t;

  function automatic logic [N_REQ-1:0] idx_onehot(input req_idx_t idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - first set request bit at or after ptr, searching modulo 4
module rr_pick4
  import packet_mux_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  req_idx_t         i_ptr,
  output logic             o_found,
  output req_idx_t         o_idx
);

  req_idx_t w_cand;

  // Walk from the farthest offset down so the closest hit to ptr is the one kept.
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_ptr;
    w_cand  = i_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = i_ptr + req_idx_t'(k);
      if (i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/packet_mux_arbiter.sv
// rtl/packet_mux_arbiter.sv - packet-boundary round-robin mux of 4 streams into one registered output
module packet_mux_arbiter
  import packet_mux_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_up_valid,
  input  logic [N_REQ-1:0] i_up_last,
  input  logic [WIDTH-1:0] i_up_data0,
  input  logic [WIDTH-1:0] i_up_data1,
  input  logic [WIDTH-1:0] i_up_data2,
  input  logic [WIDTH-1:0] i_up_data3,
  output logic [N_REQ-1:0] o_up_ready,
  output logic             o_down_valid,
  input  logic             i_down_ready,
  output logic [WIDTH-1:0] o_down_data,
  output logic             o_down_last,
  output req_idx_t         o_down_src,
  output req_idx_t         o_sel
);

  logic             r_locked;
  logic             w_locked_nxt;
  req_idx_t         r_gnt;
  req_idx_t         w_gnt_nxt;
  req_idx_t         r_ptr;
  req_idx_t         w_ptr_nxt;
  logic             w_pick_found;
  req_idx_t         w_pick_idx;
  req_idx_t         w_win;
  logic             w_load_en;
  logic [WIDTH-1:0] w_mux_data;
  logic             w_mux_last;

  logic             r_down_valid;
  logic [WIDTH-1:0] r_down_data;
  logic             r_down_last;
  req_idx_t         r_down_src;

  rr_pick4 u_pick (
    .i_req   (i_up_valid),
    .i_ptr   (r_ptr),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_locked <= 1'b0;
      r_gnt    <= '0;
      r_ptr    <= '0;
    end else begin
      r_locked <= w_locked_nxt;
      r_gnt    <= w_gnt_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_locked_nxt = r_locked;
    w_gnt_nxt    = r_gnt;
    w_ptr_nxt    = r_ptr;
    if (w_load_en) begin
      if (w_mux_last) begin
        w_locked_nxt = 1'b0;
        w_ptr_nxt    = w_win + req_idx_t'(1);
      end else begin
        w_locked_nxt = 1'b1;
        w_gnt_nxt    = w_win;
      end
    end
  end

  // While locked the owner keeps the channel even when it is idle (bubble).
  always_comb begin
    w_win = r_ptr;
    if (r_locked) begin
      w_win = r_gnt;
    end else if (w_pick_found) begin
      w_win = w_pick_idx;
    end
    w_load_en  = !i_rst && i_up_valid[w_win] && (!r_down_valid || i_down_ready);
    o_up_ready = w_load_en ? idx_onehot(w_win) : '0;
    o_sel      = w_win;
  end

  always_comb begin
    w_mux_last = i_up_last[w_win];
    case (w_win)
      2'd0:    w_mux_data = i_up_data0;
      2'd1:    w_mux_data = i_up_data1;
      2'd2:    w_mux_data = i_up_data2;
      default: w_mux_data = i_up_data3;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_down_valid <= 1'b0;
      r_down_data  <= '0;
      r_down_last  <= 1'b0;
      r_down_src   <= '0;
    end else if (w_load_en) begin
      r_down_valid <= 1'b1;
      r_down_data  <= w_mux_data;
      r_down_last  <= w_mux_last;
      r_down_src   <= w_win;
    end else if (i_down_ready) begin
      r_down_valid <= 1'b0;
    end
  end

  assign o_down_valid = r_down_valid;
  assign o_down_data  = r_down_data;
  assign o_down_last  = r_down_last;
  assign o_down_src   = r_down_src;

endmodule
